// File: rtl/bsk_prd_bus_master.sv
// BSK PRD host bus initiator: turns single-word read/write requests into
// timed CS/address/strobe cycles and returns read data with a done pulse.
module bsk_prd_bus_master #(
  parameter logic [3:0]  CS         = 4'b1011,
  parameter logic [3:0]  CS_IDLE    = 4'b0000,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oRData,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  output logic [15:0] oDOut,
  output logic        oDOe,
  input  logic [15:0] iDIn
);

  // Zero-length phases are stretched to one clock.
  localparam int unsigned SetupEff  = (SETUP_CYC  == 0) ? 1 : SETUP_CYC;
  localparam int unsigned StrobeEff = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
  localparam int unsigned HoldEff   = (HOLD_CYC   == 0) ? 1 : HOLD_CYC;
  localparam logic [3:0]  SetupLoad  = 4'(SetupEff - 1);
  localparam logic [3:0]  StrobeLoad = 4'(StrobeEff - 1);
  localparam logic [3:0]  HoldLoad   = 4'(HoldEff - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [3:0] phaseCnt;
  logic       isWrite;

  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      state    <= IDLE;
      phaseCnt <= 4'd0;
      isWrite  <= 1'b0;
      oCS      <= CS_IDLE;
      oA       <= 2'd0;
      oRd      <= 1'b1;
      oWr      <= 1'b1;
      oDOe     <= 1'b0;
      oDOut    <= 16'h0000;
      oRData   <= 16'h0000;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iReq) begin
            state    <= SETUP;
            phaseCnt <= SetupLoad;
            isWrite  <= iWe;
            oCS      <= CS;
            oA       <= iAddr;
            oBusy    <= 1'b1;
            oDOe     <= iWe;
            oDOut    <= iWe ? iWData : 16'h0000;
          end
        end
        SETUP: begin
          if (phaseCnt == 4'd0) begin
            state    <= STROBE;
            phaseCnt <= StrobeLoad;
            oRd      <= isWrite;
            oWr      <= ~isWrite;
          end else begin
            phaseCnt <= phaseCnt - 4'd1;
          end
        end
        STROBE: begin
          // Read data is taken on the edge that releases the strobe.
          if (phaseCnt == 4'd0) begin
            state    <= HOLD;
            phaseCnt <= HoldLoad;
            oRd      <= 1'b1;
            oWr      <= 1'b1;
            if (!isWrite) oRData <= iDIn;
          end else begin
            phaseCnt <= phaseCnt - 4'd1;
          end
        end
        HOLD: begin
          if (phaseCnt == 4'd0) begin
            state <= IDLE;
            oCS   <= CS_IDLE;
            oDOe  <= 1'b0;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
